// File: rtl/hack_io_device_regs.sv
// Hack CPU I/O responder: display/LED write registers, 4-digit 7-seg scan, switch sync, button debounce.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero nibble.
module hack_io_device_regs #(
    parameter int unsigned REFRESH_DIV     = 100000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seg_we,
    input  logic        led_we,
    input  logic [15:0] io_data_in,
    input  logic [15:0] sw_raw,
    input  logic [4:0]  btn_raw,
    output logic [15:0] sw_data,
    output logic [4:0]  btn_data,
    output logic [15:0] led,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int unsigned RC_W  = $clog2(REFRESH_DIV);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned N_BTN = 5;

    logic [15:0]     seg_reg_q, led_q;
    logic [15:0]     sw_s1_q, sw_s2_q;
    logic [4:0]      btn_s1_q, btn_s2_q;
    logic [4:0]      btn_stable_q, btn_stable_d;
    logic [DB_W-1:0] db_cnt_q [N_BTN];
    logic [DB_W-1:0] db_cnt_d [N_BTN];
    logic [RC_W-1:0] rc_q, rc_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      nib;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // Scan sequencing and pin pattern for the current digit
    always_comb begin
        rc_d  = rc_q + RC_W'(1);
        idx_d = idx_q;
        if (rc_q == RC_W'(REFRESH_DIV - 1)) begin
            rc_d  = '0;
            idx_d = idx_q + 2'd1;
        end
        nib   = seg_reg_q[{idx_q, 2'b00} +: 4];
        an_d  = ~(4'b0001 << idx_q);
        seg_d = hex7(nib);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        case (idx_q)
            2'd1: if (seg_reg_q[15:4]  == 12'h000) seg_d = 7'h7F;
            2'd2: if (seg_reg_q[15:8]  == 8'h00)   seg_d = 7'h7F;
            2'd3: if (seg_reg_q[15:12] == 4'h0)    seg_d = 7'h7F;
            default: ;
        endcase
`endif
    end

    // Per-button debounce: accept a new level only after DEBOUNCE_CYCLES of disagreement
    always_comb begin
        btn_stable_d = btn_stable_q;
        for (int i = 0; i < N_BTN; i++) begin
            db_cnt_d[i] = '0;
            if (btn_s2_q[i] != btn_stable_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    btn_stable_d[i] = btn_s2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_reg_q    <= '0;
            led_q        <= '0;
            sw_s1_q      <= '0;
            sw_s2_q      <= '0;
            btn_s1_q     <= '0;
            btn_s2_q     <= '0;
            btn_stable_q <= '0;
            for (int i = 0; i < N_BTN; i++) db_cnt_q[i] <= '0;
            rc_q         <= '0;
            idx_q        <= '0;
            an_q         <= 4'hF;
            seg_q        <= 7'h7F;
        end else begin
            if (seg_we) seg_reg_q <= io_data_in;
            if (led_we) led_q     <= io_data_in;
            sw_s1_q      <= sw_raw;
            sw_s2_q      <= sw_s1_q;
            btn_s1_q     <= btn_raw;
            btn_s2_q     <= btn_s1_q;
            btn_stable_q <= btn_stable_d;
            for (int i = 0; i < N_BTN; i++) db_cnt_q[i] <= db_cnt_d[i];
            rc_q         <= rc_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign sw_data  = sw_s2_q;
    assign btn_data = btn_stable_q;
    assign led      = led_q;
    assign seg      = seg_q;
    assign an       = an_q;
    assign dp       = 1'b1;

endmodule

// File: tb/tb_hack_io_device_regs.sv
// Self-checking bench for hack_io_device_regs: vector table plus due-cycle scoreboard and an independent scan model.
module tb_hack_io_device_regs;

    localparam int unsigned RDIV = 4;
    localparam int unsigned DB   = 16;
    localparam int SEL_LED = 0, SEL_SW = 1, SEL_BTN = 2, SEL_AN = 3, SEL_SEG = 4;
    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk, rst_n, seg_we, led_we, dp;
    logic [15:0] io_data_in, sw_raw, sw_data, led;
    logic [4:0]  btn_raw, btn_data;
    logic [6:0]  seg;
    logic [3:0]  an;

    hack_io_device_regs #(.REFRESH_DIV(RDIV), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n), .seg_we(seg_we), .led_we(led_we), .io_data_in(io_data_in),
        .sw_raw(sw_raw), .btn_raw(btn_raw), .sw_data(sw_data), .btn_data(btn_data),
        .led(led), .seg(seg), .dp(dp), .an(an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int due; int sel; logic [15:0] exp; } exp_t;
    typedef struct { bit s_we; bit l_we; logic [15:0] d; logic [15:0] exp_led; } vec_t;

    exp_t        sbq[$];
    vec_t        tab[5];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          m_rc, m_idx;
    logic [15:0] m_seg;

    function automatic logic [15:0] sig(input int sel);
        case (sel)
            SEL_LED: return led;
            SEL_SW:  return sw_data;
            SEL_BTN: return {11'h0, btn_data};
            SEL_AN:  return {12'h0, an};
            default: return {9'h0, seg};
        endcase
    endfunction

    function automatic string sname(input int sel);
        case (sel)
            SEL_LED: return "led";
            SEL_SW:  return "sw_data";
            SEL_BTN: return "btn_data";
            SEL_AN:  return "an";
            default: return "seg";
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int idx, input logic [15:0] v);
        logic [15:0] hi;
        hi = v >> (4 * idx);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (idx > 0 && hi == 16'h0) return 7'h7F;
`endif
        return HEX[hi[3:0]];
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic expect_at(input int lat, input int sel, input logic [15:0] e);
        exp_t x;
        x.due = cyc + lat; x.sel = sel; x.exp = e;
        sbq.push_back(x);
    endtask

    // One clock edge, then retire every scoreboard entry due on it
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = sbq.size() - 1; i >= 0; i--) begin
            if (sbq[i].due == cyc) begin
                check(sname(sbq[i].sel), sig(sbq[i].sel), sbq[i].exp);
                sbq.delete(i);
            end
        end
    endtask

    // Drive one cycle of write strobes and predict the scan pins from the pre-edge model state
    task automatic scan_step(input bit s_we, input bit l_we, input logic [15:0] d);
        logic [3:0] a;
        a = ~(4'b0001 << m_idx);
        expect_at(1, SEL_AN, {12'h0, a});
        expect_at(1, SEL_SEG, {9'h0, exp_seg(m_idx, m_seg)});
        seg_we = s_we; led_we = l_we; io_data_in = d;
        tick();
        seg_we = 1'b0; led_we = 1'b0;
        if (s_we) m_seg = d;
        if (m_rc == RDIV - 1) begin
            m_rc  = 0;
            m_idx = (m_idx + 1) % 4;
        end else begin
            m_rc++;
        end
    endtask

    task automatic reset_checks();
        check("rst_led", led, 16'h0);
        check("rst_an", {12'h0, an}, 16'h000F);
        check("rst_seg", {9'h0, seg}, 16'h007F);
        check("rst_dp", {15'h0, dp}, 16'h0001);
        check("rst_sw", sw_data, 16'h0);
        check("rst_btn", {11'h0, btn_data}, 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0] = '{1'b0, 1'b1, 16'hA5A5, 16'hA5A5};
        tab[1] = '{1'b1, 1'b0, 16'h1234, 16'hA5A5};
        tab[2] = '{1'b1, 1'b1, 16'h0F0F, 16'h0F0F};
        tab[3] = '{1'b0, 1'b0, 16'hFFFF, 16'h0F0F};
        tab[4] = '{1'b0, 1'b1, 16'h0000, 16'h0000};

        rst_n = 1'b0; seg_we = 1'b0; led_we = 1'b0;
        io_data_in = '0; sw_raw = '0; btn_raw = '0;
        tick(); tick();
        reset_checks();
        rst_n = 1'b1;
        m_rc = 0; m_idx = 0; m_seg = 16'h0;

        // Scan of 0x12AF through a full wrap, then a mid-scan write of 0x0042
        scan_step(1'b1, 1'b0, 16'h12AF);
        for (int k = 0; k < 17; k++) scan_step(1'b0, 1'b0, 16'h0);
        scan_step(1'b1, 1'b0, 16'h0042);
        for (int k = 0; k < 18; k++) scan_step(1'b0, 1'b0, 16'h0);

        // Write-strobe vectors
        for (int v = 0; v < 5; v++) begin
            expect_at(1, SEL_LED, tab[v].exp_led);
            scan_step(tab[v].s_we, tab[v].l_we, tab[v].d);
        end
        for (int k = 0; k < 16; k++) scan_step(1'b0, 1'b0, 16'h0);

        // Switch synchroniser latency
        sw_raw = 16'h8001;
        expect_at(1, SEL_SW, 16'h0000);
        expect_at(2, SEL_SW, 16'h8001);
        tick(); tick();
        sw_raw = 16'h1234;
        expect_at(1, SEL_SW, 16'h8001);
        expect_at(2, SEL_SW, 16'h1234);
        tick(); tick();

        // Button: short glitch rejected, long press and release accepted on edge 18
        btn_raw = 5'b00100;
        for (int k = 1; k <= 10; k++) begin expect_at(1, SEL_BTN, 16'h0); tick(); end
        btn_raw = 5'b00000;
        for (int k = 1; k <= 20; k++) begin expect_at(1, SEL_BTN, 16'h0); tick(); end
        btn_raw = 5'b00100;
        for (int k = 1; k <= 30; k++) begin
            expect_at(1, SEL_BTN, (k >= 18) ? 16'h0004 : 16'h0000);
            tick();
        end
        btn_raw = 5'b00000;
        for (int k = 1; k <= 22; k++) begin
            expect_at(1, SEL_BTN, (k >= 18) ? 16'h0000 : 16'h0004);
            tick();
        end

        // Asynchronous reset mid-scan with state loaded
        led_we = 1'b1; io_data_in = 16'hFFFF; sw_raw = 16'hFFFF; btn_raw = 5'b00100;
        tick();
        led_we = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        check("pre_rst_led", led, 16'hFFFF);
        check("pre_rst_btn", {11'h0, btn_data}, 16'h0004);
        #3 rst_n = 1'b0;
        #1 reset_checks();
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_an", {12'h0, an}, 16'h000E);
        check("post_rst_seg", {9'h0, seg}, 16'h0040);
        check("post_rst_sw", sw_data, 16'h0);

        check("sb_drain", 16'(sbq.size()), 16'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hack_io_device_regs.md
Name: hack_io_device_regs

Overview:
Device-side responder for the Hack CPU memory-mapped I/O window (0x6000–0x6003). It is the write target for the address decoder's seg_we/led_we/io_data_out outputs and drives the 7-segment display and LEDs. It also synchronises and debounces the Basys3 switches and buttons that the decoder returns to the CPU as sw_data (0x6000) and btn_data (0x6001).

Parameters:
REFRESH_DIV, 100000, clk cycles per displayed digit (1 ms at 100 MHz); range ≥2.
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a button change (10 ms); range ≥2.

Ports:
clk  in  1  system clock, single clock domain.
rst_n  in  1  asynchronous active-low reset.
seg_we  in  1  write strobe for the display register (0x6002).
led_we  in  1  write strobe for the LED register (0x6003).
io_data_in  in  16  write data from the decoder's io_data_out.
sw_raw  in  16  asynchronous slide-switch pins.
btn_raw  in  5  asynchronous push-button pins.
sw_data  out  16  synchronised switches.
btn_data  out  5  debounced buttons.
led  out  16  LED drive, active high.
seg  out  7  cathodes {g,f,e,d,c,b,a}, active low.
dp  out  1  decimal point, active low; held 1 (off).
an  out  4  digit anodes, active low; an[0] is the rightmost digit.

Behaviour:
- Reset (async, rst_n=0) forces: seg_reg=0, led=0, sw_data=0, btn_data=0, an=4'hF, seg=7'h7F, dp=1, refresh counter=0, digit idx=0, all sync flops=0, debounce counters=0.
- Writes: on a clk edge with seg_we=1, seg_reg<=io_data_in. On a clk edge with led_we=1, led<=io_data_in. The new value is visible after that edge. Both strobes high in the same cycle: both registers load. A strobe low leaves its register unchanged.
- Switches: 2-flop synchroniser per bit. sw_data follows sw_raw with 2-cycle latency; no debounce.
- Buttons: 2-flop synchroniser, then a per-bit debouncer with its own counter.
  - If sync == stable, the counter clears.
  - Otherwise the counter increments.
  - When counter == DEBOUNCE_CYCLES-1 and sync != stable: stable<=sync, counter<=0.
  - btn_data = stable. A clean edge reaches btn_data on the (DEBOUNCE_CYCLES+2)th edge after the raw change.
  - A mismatch lasting fewer than DEBOUNCE_CYCLES cycles is rejected.
- Display scan:
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps. On wrap, idx<=idx+1 mod 4 (3→0).
  - an and seg are registered every cycle from the current idx and seg_reg: an<=~(4'b1<<idx), seg<=hex(seg_reg[4*idx+3 -: 4]).
  - Latency: 1 cycle from an idx change or seg_reg load to the pins.
  - an and seg change on the same edge, so there is no cross-digit ghosting.
- Hex decode, active low {g..a}: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- A write mid-scan updates the digit pattern without resetting the scan. Reset mid-scan restarts at idx=0.

Optional Feature:
SEG_LEADING_ZERO_BLANK_EN.
- Defined: digits above the most significant non-zero nibble show seg=7'h7F (blank); their an is still driven normally. Digit 0 is never blanked. seg_reg=0 shows "   0".
- Undefined: all four digits always decode, e.g. "0042".

Test Plan:
1. Reset: drive rst_n=0 mid-scan with led=0xFFFF loaded -> without a clock edge, led=0, an=F, seg=7F, sw_data=0, btn_data=0. Release -> after 1 edge, an=E, seg=40.
2. Display scan: REFRESH_DIV=4, seg_we with io_data_in=0x12AF -> across successive refresh periods an/seg = E/0E, D/08, B/24, 7/79, then back to E/0E after 16 cycles.
3. LED register: led_we with 0xA5A5 -> led=A5A5 next cycle. Then seg_we with 0x1234 and led_we=0 -> led stays A5A5. Both strobes with 0x0F0F -> led=0F0F and seg_reg=0F0F.
4. Switches: sw_raw 0x0000→0x8001 -> sw_data=8001 exactly 2 edges later, unchanged before that.
5. Buttons: DEBOUNCE_CYCLES=16.
   - 10-cycle pulse on btn_raw[2] -> btn_data stays 0.
   - 30-cycle hold -> btn_data=5'b00100 on edge 18 after the rise.
   - Release -> btn_data=0 on edge 18 after the fall.
6. Blanking: seg_reg=0x0042, both builds -> macro defined: digits 3,2 seg=7F, digits 1,0 = 19, 24. Macro undefined: digits 3,2 seg=40.
